// File: rtl/qspi_wr_buffer.sv
// qspi_wr_buffer: transmit-side buffer for QSPI indirect-mode writes.
// Words written to the TX data register are queued in a word FIFO. On an
// indirect-write start they are unpacked LSB-first into bytes and handed to
// the shifter over a valid/ready handshake until the programmed byte count
// has been sent, after which done_out pulses for one cycle.
//
// Ports:
//   h_clk, h_rst          clock, asynchronous active-high reset
//   wr_en_in, wr_data_in  push strobe and 32-bit word
//   flush_in              synchronous clear of FIFO, FSM and error flag
//   start_in, byte_cnt_in start pulse and byte count (0 encodes 256)
//   byte_rdy_in           shifter ready
//   byte_valid_out, byte_out, last_byte_out   byte stream to the shifter
//   done_out, busy_out    transfer complete pulse, FSM not idle
//   full_out, empty_out, level_out            FIFO status
//   overflow_err_out      sticky: push attempted while full
module qspi_wr_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          h_clk,
    input  logic          h_rst,
    input  logic          wr_en_in,
    input  logic [31:0]   wr_data_in,
    input  logic          flush_in,
    input  logic          start_in,
    input  logic [7:0]    byte_cnt_in,
    input  logic          byte_rdy_in,
    output logic          byte_valid_out,
    output logic [7:0]    byte_out,
    output logic          last_byte_out,
    output logic          done_out,
    output logic          busy_out,
    output logic          full_out,
    output logic          empty_out,
    output logic [AW:0]   level_out,
    output logic          overflow_err_out
);

    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = 9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     hold_q, hold_d;
    logic [1:0]      idx_q, idx_d;
    logic [RW-1:0]   rem_q, rem_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;
    logic [7:0]      byte_q, byte_d;
    logic            last_q, last_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            push_c;
    logic            pop_c;
    logic [31:0]     mem_q [DEPTH];

    // Next-state logic for FIFO bookkeeping, transmit FSM and registered outputs
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        push_c  = 1'b0;
        pop_c   = 1'b0;

        // Full is judged on the registered flag, so a same-cycle pop never frees room
        if (wr_en_in) begin
            if (full_q) begin
                ovf_d = 1'b1;
            end else begin
                push_c = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    rem_d   = (byte_cnt_in == 8'd0) ? RW'(256) : RW'(byte_cnt_in);
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!empty_q) begin
                    pop_c   = 1'b1;
                    hold_d  = mem_q[rptr_q];
                    idx_d   = 2'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (byte_rdy_in) begin
                    rem_d = rem_q - RW'(1);
                    idx_d = idx_q + 2'd1;
                    if (rem_q == RW'(1)) begin
                        state_d = S_DONE;
                    end else if (idx_q == 2'd3) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush dominates everything, including a same-cycle push or start
        if (flush_in) begin
            push_c  = 1'b0;
            pop_c   = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_IDLE;
            hold_d  = 32'd0;
            idx_d   = 2'd0;
            rem_d   = RW'(0);
        end

        if (push_c) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + AW'(1);
        end
        level_d = level_q + LW'(push_c) - LW'(pop_c);

        if (flush_in) begin
            wptr_d  = AW'(0);
            rptr_d  = AW'(0);
            level_d = LW'(0);
        end

        valid_d = (state_d == S_SEND);
        byte_d  = valid_d ? hold_d[{idx_d, 3'b000} +: 8] : 8'd0;
        last_d  = valid_d && (rem_d == RW'(1));
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        full_d  = (level_d == LW'(DEPTH));
        empty_d = (level_d == LW'(0));
    end

    // State and output registers
    always_ff @(posedge h_clk or posedge h_rst) begin
        if (h_rst) begin
            state_q <= S_IDLE;
            wptr_q  <= AW'(0);
            rptr_q  <= AW'(0);
            level_q <= LW'(0);
            hold_q  <= 32'd0;
            idx_q   <= 2'd0;
            rem_q   <= RW'(0);
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            byte_q  <= 8'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Word storage
    always_ff @(posedge h_clk or posedge h_rst) begin
        if (h_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (push_c) begin
            mem_q[wptr_q] <= wr_data_in;
        end
    end

    assign byte_valid_out   = valid_q;
    assign byte_out         = byte_q;
    assign last_byte_out    = last_q;
    assign done_out         = done_q;
    assign busy_out         = busy_q;
    assign full_out         = full_q;
    assign empty_out        = empty_q;
    assign level_out        = level_q;
    assign overflow_err_out = ovf_q;

endmodule

// File: tb/tb_qspi_wr_buffer.sv
// Testbench for qspi_wr_buffer: directed scenarios plus randomized transfers
// checked against a byte-stream model (words expanded LSB-first).
module tb_qspi_wr_buffer;

    logic        h_clk = 1'b0;
    logic        h_rst;
    logic        wr_en_in;
    logic [31:0] wr_data_in;
    logic        flush_in;
    logic        start_in;
    logic [7:0]  byte_cnt_in;
    logic        byte_rdy_in;
    logic        byte_valid_out;
    logic [7:0]  byte_out;
    logic        last_byte_out;
    logic        done_out;
    logic        busy_out;
    logic        full_out;
    logic        empty_out;
    logic [3:0]  level_out;
    logic        overflow_err_out;

    int tests_run = 0;
    int failed    = 0;
    int cyc       = 0;
    logic [31:0] stream[$];

    qspi_wr_buffer #(.DEPTH(8), .AW(3)) dut (
        .h_clk           (h_clk),
        .h_rst           (h_rst),
        .wr_en_in        (wr_en_in),
        .wr_data_in      (wr_data_in),
        .flush_in        (flush_in),
        .start_in        (start_in),
        .byte_cnt_in     (byte_cnt_in),
        .byte_rdy_in     (byte_rdy_in),
        .byte_valid_out  (byte_valid_out),
        .byte_out        (byte_out),
        .last_byte_out   (last_byte_out),
        .done_out        (done_out),
        .busy_out        (busy_out),
        .full_out        (full_out),
        .empty_out       (empty_out),
        .level_out       (level_out),
        .overflow_err_out(overflow_err_out)
    );

    always #5 h_clk = ~h_clk;

    task automatic tick();
        @(posedge h_clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        h_rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({byte_valid_out, byte_out, last_byte_out, done_out, busy_out, full_out,
             empty_out, level_out, overflow_err_out} !== {1'b0, 8'h00, 4'b0000, 1'b1, 4'h0, 1'b0}) begin
            failed++;
            $display("FAIL reset_outputs: valid=%b byte=%h last=%b done=%b busy=%b full=%b empty=%b level=%0d ovf=%b, required all 0 except empty=1",
                     byte_valid_out, byte_out, last_byte_out, done_out, busy_out, full_out,
                     empty_out, level_out, overflow_err_out);
        end
        h_rst = 1'b0;
        tick();
    endtask

    // Runs one indirect transfer of n bytes fed from the word stream.
    task automatic xfer(input string name, input int n, input int prepush,
                        input int holdoff, input int pct);
        int need, pushed, hs, start_cyc, first_v, last_hs, done_cyc, guard;
        bit done_seen, prev_stall, rdy;
        logic [7:0] prev_byte, exp_b;
        logic [31:0] w;
        need = (n + 3) / 4;
        pushed = 0;
        while (pushed < prepush && pushed < stream.size()) begin
            wr_en_in = 1'b1;
            wr_data_in = stream[pushed];
            pushed++;
            tick();
        end
        wr_en_in = 1'b0;
        start_in = 1'b1;
        byte_cnt_in = 8'(n);
        start_cyc = cyc;
        tick();
        start_in = 1'b0;
        tests_run++;
        if (busy_out !== 1'b1) begin
            failed++;
            $display("FAIL %s_busy_after_start: got %b, required 1", name, busy_out);
        end
        hs = 0; first_v = -1; last_hs = -1; done_cyc = -1; guard = 0;
        done_seen = 0; prev_stall = 0; prev_byte = 8'h00;
        while (!done_seen && guard < 5000) begin
            if (byte_valid_out === 1'b1 && first_v < 0) first_v = cyc;
            if (prev_stall) begin
                tests_run++;
                if (byte_valid_out !== 1'b1 || byte_out !== prev_byte) begin
                    failed++;
                    $display("FAIL %s_hold_stable: valid=%b byte=%h, required valid=1 byte=%h",
                             name, byte_valid_out, byte_out, prev_byte);
                end
            end
            if (holdoff > 0 && cyc - start_cyc <= holdoff) begin
                tests_run++;
                if (busy_out !== 1'b1 || byte_valid_out !== 1'b0) begin
                    failed++;
                    $display("FAIL %s_underrun_stall: busy=%b valid=%b, required busy=1 valid=0",
                             name, busy_out, byte_valid_out);
                end
            end
            if (done_out === 1'b1) begin
                done_seen = 1;
                done_cyc = cyc;
                tests_run++;
                if (hs != n || cyc != last_hs + 1) begin
                    failed++;
                    $display("FAIL %s_done: handshakes=%0d at cycle %0d, required %0d with done one cycle after last (%0d)",
                             name, hs, cyc, n, last_hs);
                end
            end else begin
                wr_en_in = 1'b0;
                if (pushed < stream.size() && cyc - start_cyc > holdoff && pushed - hs / 4 < 4) begin
                    wr_en_in = 1'b1;
                    wr_data_in = stream[pushed];
                    pushed++;
                end
                rdy = ($urandom_range(0, 99) < pct);
                byte_rdy_in = rdy;
                if (byte_valid_out === 1'b1 && rdy) begin
                    tests_run++;
                    if (hs >= n) begin
                        failed++;
                        $display("FAIL %s_extra_byte: byte %h accepted after %0d bytes", name, byte_out, hs);
                    end else begin
                        w = stream[hs / 4] >> (8 * (hs % 4));
                        exp_b = w[7:0];
                        if (byte_out !== exp_b || last_byte_out !== (hs == n - 1)) begin
                            failed++;
                            $display("FAIL %s_byte%0d: byte=%h last=%b, required byte=%h last=%b",
                                     name, hs, byte_out, last_byte_out, exp_b, (hs == n - 1));
                        end
                    end
                    hs++;
                    last_hs = cyc;
                end
                prev_stall = (byte_valid_out === 1'b1) && !rdy;
                prev_byte = byte_out;
                tick();
                guard++;
            end
        end
        wr_en_in = 1'b0;
        byte_rdy_in = 1'b0;
        if (!done_seen) begin
            tests_run++;
            failed++;
            $display("FAIL %s_timeout: no done_out after %0d cycles, %0d of %0d bytes", name, guard, hs, n);
        end
        if (prepush > 0 && holdoff == 0) begin
            tests_run++;
            if (first_v != start_cyc + 2) begin
                failed++;
                $display("FAIL %s_first_latency: first valid at +%0d, required +2", name, first_v - start_cyc);
            end
        end
        if (pct == 100 && prepush >= need && holdoff == 0) begin
            tests_run++;
            if (done_cyc - start_cyc != 2 + n + need - 1) begin
                failed++;
                $display("FAIL %s_total_latency: done at +%0d, required +%0d", name,
                         done_cyc - start_cyc, 2 + n + need - 1);
            end
        end
        tests_run++;
        if (level_out !== 4'(pushed - need) || empty_out !== (pushed == need)) begin
            failed++;
            $display("FAIL %s_level_after: level=%0d empty=%b, required level=%0d", name,
                     level_out, empty_out, pushed - need);
        end
        tick();
        tests_run++;
        if (done_out !== 1'b0 || busy_out !== 1'b0 || byte_valid_out !== 1'b0) begin
            failed++;
            $display("FAIL %s_idle_after: done=%b busy=%b valid=%b, required 0 0 0", name,
                     done_out, busy_out, byte_valid_out);
        end
    endtask

    task automatic test_single_word();
        stream = '{32'h44332211};
        xfer("single_word", 4, 1, 0, 100);
    endtask

    task automatic test_word_boundary();
        stream = '{32'h04030201, 32'h08070605};
        xfer("word_boundary", 6, 2, 0, 100);
    endtask

    task automatic test_overflow_flush();
        for (int i = 0; i < 9; i++) begin
            wr_en_in = 1'b1;
            wr_data_in = $urandom;
            tick();
            if (i == 7) begin
                tests_run++;
                if (full_out !== 1'b1 || level_out !== 4'd8 || overflow_err_out !== 1'b0) begin
                    failed++;
                    $display("FAIL full_at_8: full=%b level=%0d ovf=%b, required 1 8 0",
                             full_out, level_out, overflow_err_out);
                end
            end
        end
        wr_en_in = 1'b0;
        tests_run++;
        if (full_out !== 1'b1 || level_out !== 4'd8 || overflow_err_out !== 1'b1) begin
            failed++;
            $display("FAIL overflow_9th: full=%b level=%0d ovf=%b, required 1 8 1",
                     full_out, level_out, overflow_err_out);
        end
        flush_in = 1'b1;
        wr_en_in = 1'b1;
        start_in = 1'b1;
        byte_cnt_in = 8'd4;
        tick();
        flush_in = 1'b0;
        wr_en_in = 1'b0;
        start_in = 1'b0;
        tests_run++;
        if (level_out !== 4'd0 || empty_out !== 1'b1 || full_out !== 1'b0 ||
            overflow_err_out !== 1'b0 || busy_out !== 1'b0) begin
            failed++;
            $display("FAIL flush: level=%0d empty=%b full=%b ovf=%b busy=%b, required 0 1 0 0 0",
                     level_out, empty_out, full_out, overflow_err_out, busy_out);
        end
    endtask

    task automatic test_underrun();
        stream = '{32'h0000BBAA};
        xfer("underrun", 2, 0, 5, 100);
    endtask

    task automatic test_backpressure();
        stream = '{$urandom, $urandom, $urandom};
        xfer("backpressure", 11, 2, 0, 45);
    endtask

    task automatic test_random();
        int n, need, pre;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 40);
            need = (n + 3) / 4;
            stream.delete();
            for (int k = 0; k < need; k++) stream.push_back($urandom);
            pre = $urandom_range(0, (need < 8) ? need : 8);
            xfer("random", n, pre, 0, $urandom_range(30, 100));
        end
    endtask

    task automatic test_max_count();
        stream.delete();
        for (int k = 0; k < 64; k++) stream.push_back($urandom);
        xfer("max_count", 256, 2, 0, 85);
    endtask

    task automatic test_reset_mid_send();
        int guard;
        wr_en_in = 1'b1;
        wr_data_in = 32'hDEADBEEF;
        tick();
        wr_en_in = 1'b0;
        start_in = 1'b1;
        byte_cnt_in = 8'd4;
        tick();
        start_in = 1'b0;
        guard = 0;
        while (byte_valid_out !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        tests_run++;
        if (byte_valid_out !== 1'b1) begin
            failed++;
            $display("FAIL reset_mid_send_setup: valid=%b, required 1", byte_valid_out);
        end
        #2;
        h_rst = 1'b1;
        #1;
        tests_run++;
        if ({byte_valid_out, byte_out, last_byte_out, done_out, busy_out, full_out,
             empty_out, level_out, overflow_err_out} !== {1'b0, 8'h00, 4'b0000, 1'b1, 4'h0, 1'b0}) begin
            failed++;
            $display("FAIL reset_mid_send: valid=%b byte=%h busy=%b empty=%b level=%0d, required 0 00 0 1 0",
                     byte_valid_out, byte_out, busy_out, empty_out, level_out);
        end
        tick();
        h_rst = 1'b0;
        tick();
        tests_run++;
        if (busy_out !== 1'b0 || empty_out !== 1'b1 || byte_valid_out !== 1'b0) begin
            failed++;
            $display("FAIL after_reset_release: busy=%b empty=%b valid=%b, required 0 1 0",
                     busy_out, empty_out, byte_valid_out);
        end
    endtask

    initial begin
        h_rst = 1'b1;
        wr_en_in = 1'b0;
        wr_data_in = 32'd0;
        flush_in = 1'b0;
        start_in = 1'b0;
        byte_cnt_in = 8'd0;
        byte_rdy_in = 1'b0;
        test_reset();
        test_single_word();
        test_word_boundary();
        test_overflow_flush();
        test_underrun();
        test_backpressure();
        test_random();
        test_max_count();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/qspi_wr_buffer.md
Name: qspi_wr_buffer

Overview:
Transmit-side buffer between the AHB slave datapath and the QSPI shifter for indirect-mode writes.
- Accepts 32-bit words written to the TX data register (one-cycle write strobe) and stores them in a word FIFO.
- On an indirect-write start, unpacks words into bytes, least-significant byte first.
- Presents the bytes to the shifter with a valid/ready handshake until the programmed byte count is sent, then pulses done.

Parameters:
DEPTH, 8, number of 32-bit word entries in the FIFO (power of two, >=2)
AW, 3, pointer width, log2(DEPTH)

Ports:
h_clk  input  1  system clock, all state updates on rising edge
h_rst  input  1  asynchronous, active-high reset
wr_en_in  input  1  one-cycle strobe: push wr_data_in (TX data register write)
wr_data_in  input  32  word to push
flush_in  input  1  synchronous clear of FIFO, FSM and error flag
start_in  input  1  one-cycle pulse: begin indirect transmit of byte_cnt_in bytes
byte_cnt_in  input  8  bytes to send; 0 encodes 256
byte_rdy_in  input  1  shifter ready to accept a byte
byte_valid_out  output  1  byte_out is valid
byte_out  output  8  current byte
last_byte_out  output  1  current byte is the final byte of the transfer
done_out  output  1  one-cycle pulse after final byte handshake
busy_out  output  1  FSM not in IDLE
full_out  output  1  FIFO holds DEPTH words
empty_out  output  1  FIFO holds 0 words
level_out  output  AW+1  words currently in FIFO
overflow_err_out  output  1  sticky: push attempted while full

Behaviour:
- Reset (h_rst high, asynchronous):
  - FIFO pointers and level are 0; FSM is IDLE.
  - All outputs are 0 except empty_out=1.
  - Hold register, byte index and remaining counter are 0.
- FIFO:
  - Push when wr_en_in && !full_out; data is visible to the pop side the next cycle.
  - Push while full: the word is dropped and overflow_err_out is set (sticky).
  - A pop in the same cycle does not unblock a push.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo DEPTH.
  - full_out, empty_out and level_out are registered, derived from level.
- FSM states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start_in loads remaining = (byte_cnt_in==0 ? 256 : byte_cnt_in), 9-bit, then goes to FETCH.
  - start_in in any other state is ignored.
- FETCH:
  - If !empty_out: pop one word into the hold register, set byte index=0, go to SEND.
  - Else stay in FETCH (underrun stall, no timeout).
- SEND:
  - byte_valid_out=1.
  - byte_out = hold[8*idx+7 : 8*idx].
  - last_byte_out = (remaining==1).
  - On byte_valid_out && byte_rdy_in: remaining decrements and idx increments.
    - If remaining was 1: go to DONE.
    - Else if idx was 3: go to FETCH.
    - Else stay in SEND.
  - byte_out and byte_valid_out hold stable while byte_rdy_in is low.
- DONE: done_out=1 for exactly one cycle, then IDLE. Unsent bytes of a partially consumed word are discarded.
- Latency:
  - start at cycle T with a non-empty FIFO: pop at T+1, first byte_valid_out at T+2.
  - A word boundary costs one bubble cycle (FETCH).
- busy_out = (state != IDLE).
- flush_in (synchronous, highest priority, any state):
  - Pointers and level cleared, overflow_err_out cleared, FSM to IDLE.
  - A wr_en_in or start_in in the same cycle is ignored.
  - No done_out pulse.
- Reset mid-transfer: immediate return to reset state; partial data is lost.

Test Plan:
1. Push 0x44332211, start with byte_cnt_in=4, byte_rdy_in tied high -> bytes 0x11,0x22,0x33,0x44 on consecutive cycles starting T+2; last_byte_out with 0x44; done_out one cycle later; empty_out=1.
2. Push 0x04030201, 0x08070605; start with byte_cnt_in=6 -> bytes 01..04, one bubble, 05,06; done_out; level_out=0; bytes 07,08 discarded.
3. Push 9 words with DEPTH=8 -> full_out=1, level_out=8, overflow_err_out=1 after the 9th push; flush_in -> level_out=0, empty_out=1, overflow_err_out=0.
4. Start with byte_cnt_in=2 on an empty FIFO -> stall in FETCH with busy_out=1 and byte_valid_out=0; push 0x0000BBAA -> bytes 0xAA,0xBB, then done_out.
5. byte_rdy_in toggled 1-0-0-1 during SEND -> byte_out and byte_valid_out held while not ready; no byte skipped or duplicated.
6. byte_cnt_in=0 with 64 words pushed over time -> exactly 256 handshakes, then done_out. Separately, assert h_rst mid-SEND -> all outputs return to reset values immediately.
